alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_defs.vh | 10 +
 rtl/parameters.vh | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_arbiter_pkg.sv
// Types and constants for the shared-ALU arbiter.
package alu_arbiter_pkg;
`include "parameters.vh"
`include "alu_arbiter_defs.vh"

   localparam int unsigned ARB_WORD_SIZE = `WORD_SIZE;

   localparam logic [4:0] OP_ADD  = `OP_ADD;
   localparam logic [4:0] OP_SUB  = `OP_SUB;
   localparam logic [4:0] OP_COMP = `OP_COMP;
   localparam logic [4:0] OP_SLI  = `OP_SLI;
   localparam logic [4:0] OP_SRI  = `OP_SRI;
   localparam logic [4:0] OP_LOAD = `OP_LOAD;

   typedef enum logic [1:0] {
      StIdle = ARB_ST_IDLE,
      StExec = ARB_ST_EXEC,
      StCapt = ARB_ST_CAPT,
      StResp = ARB_ST_RESP
   } arb_state_e;
endpackage

// File: rtl/alu_arbiter_defs.vh
// Arbiter FSM state encodings, shared between the RTL package and the bench.
`ifndef ALU_ARBITER_DEFS_VH
`define ALU_ARBITER_DEFS_VH

localparam logic [1:0] ARB_ST_IDLE = 2'd0;
localparam logic [1:0] ARB_ST_EXEC = 2'd1;
localparam logic [1:0] ARB_ST_CAPT = 2'd2;
localparam logic [1:0] ARB_ST_RESP = 2'd3;

`endif

// File: rtl/parameters.vh
// Shared datapath width and ALU opcode encodings.
`ifndef PARAMETERS_VH
`define PARAMETERS_VH

`define WORD_SIZE 16

`define OP_ADD  5'd0
`define OP_SUB  5'd1
`define OP_COMP 5'd2
`define OP_SLI  5'd3
`define OP_SRI  5'd4
`define OP_LOAD 5'd16

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches upward from ptr_i+1 with wrap.
module rr_arbiter #(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  valid_i,
   input  logic [ID_WIDTH-1:0] ptr_i,
   input  logic                en_i,
   output logic [NUM_REQ-1:0]  grant_o,
   output logic [ID_WIDTH-1:0] grant_idx_o
);

   logic [ID_WIDTH-1:0] idx;
   logic                found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      idx         = '0;
      found       = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = ID_WIDTH'((32'(ptr_i) + k) % NUM_REQ);
         if (en_i && !found && valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters: round-robin grant,
// one-cycle alu_enable pulse, captured result returned over valid/ready.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE = ARB_WORD_SIZE,
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*5-1:0]         req_opcode,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_in1,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_in2,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [WORD_SIZE-1:0]         resp_data,
   output logic [ID_WIDTH-1:0]          resp_id,
   output logic [4:0]                   alu_opcode,
   output logic [WORD_SIZE-1:0]         alu_input1,
   output logic [WORD_SIZE-1:0]         alu_input2,
   output logic                         alu_enable,
   input  logic [WORD_SIZE-1:0]         alu_out
);

   arb_state_e           state_q, state_d;
   logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
   logic [4:0]           alu_opcode_q, alu_opcode_d;
   logic [WORD_SIZE-1:0] alu_input1_q, alu_input1_d;
   logic [WORD_SIZE-1:0] alu_input2_q, alu_input2_d;
   logic                 alu_enable_q, alu_enable_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [WORD_SIZE-1:0] resp_data_q, resp_data_d;
   logic [ID_WIDTH-1:0]  resp_id_q, resp_id_d;

   logic [NUM_REQ-1:0]   grant;
   logic [ID_WIDTH-1:0]  grant_idx;
   logic [4:0]           sel_opcode;
   logic [WORD_SIZE-1:0] sel_in1, sel_in2;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_WIDTH(ID_WIDTH)
   ) u_rr_arbiter (
      .valid_i    (req_valid),
      .ptr_i      (ptr_q),
      .en_i       (state_q == StIdle),
      .grant_o    (grant),
      .grant_idx_o(grant_idx)
   );

   // Grant is one-hot, so an OR-style mux picks the winner's payload.
   always_comb begin
      sel_opcode = '0;
      sel_in1    = '0;
      sel_in2    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_opcode = req_opcode[5*i +: 5];
            sel_in1    = req_in1[WORD_SIZE*i +: WORD_SIZE];
            sel_in2    = req_in2[WORD_SIZE*i +: WORD_SIZE];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      alu_opcode_d = alu_opcode_q;
      alu_input1_d = alu_input1_q;
      alu_input2_d = alu_input2_q;
      alu_enable_d = alu_enable_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      unique case (state_q)
         StIdle: begin
            if (|grant) begin
               alu_opcode_d = sel_opcode;
               alu_input1_d = sel_in1;
               alu_input2_d = sel_in2;
               alu_enable_d = 1'b1;
               resp_id_d    = grant_idx;
               ptr_d        = grant_idx;
               state_d      = StExec;
            end
         end
         StExec: begin
            alu_enable_d = 1'b0;
            state_d      = StCapt;
         end
         StCapt: begin
            resp_data_d  = alu_out;
            resp_valid_d = 1'b1;
            state_d      = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         ptr_q        <= ID_WIDTH'(NUM_REQ - 1);
         alu_opcode_q <= '0;
         alu_input1_q <= '0;
         alu_input2_q <= '0;
         alu_enable_q <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         alu_opcode_q <= alu_opcode_d;
         alu_input1_q <= alu_input1_d;
         alu_input2_q <= alu_input2_d;
         alu_enable_q <= alu_enable_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
      end
   end

   assign req_ready  = grant;
   assign alu_opcode = alu_opcode_q;
   assign alu_input1 = alu_input1_q;
   assign alu_input2 = alu_input2_q;
   assign alu_enable = alu_enable_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int W = 16;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*5-1:0] req_opcode = '0;
   logic [N*W-1:0] req_in1 = '0;
   logic [N*W-1:0] req_in2 = '0;
   logic           resp_valid;
   logic           resp_ready = 1'b1;
   logic [W-1:0]   resp_data;
   logic [0:0]     resp_id;
   logic [4:0]     alu_opcode;
   logic [W-1:0]   alu_input1, alu_input2;
   logic           alu_enable;
   logic [W-1:0]   alu_out = '0;

   int n_tests = 0;
   int n_fail  = 0;

   alu_arbiter #(
      .WORD_SIZE(W),
      .NUM_REQ  (N),
      .ID_WIDTH (1)
   ) dut (
      .clock     (clk),
      .reset_n   (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_opcode(req_opcode),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_data (resp_data),
      .resp_id   (resp_id),
      .alu_opcode(alu_opcode),
      .alu_input1(alu_input1),
      .alu_input2(alu_input2),
      .alu_enable(alu_enable),
      .alu_out   (alu_out)
   );

   always #5 clk = ~clk;

   // Registered ALU; unhandled opcodes leave the previous result in place.
   always @(posedge clk) begin
      if (alu_enable) begin
         case (alu_opcode)
            OP_ADD:  alu_out <= alu_input1 + alu_input2;
            OP_SUB:  alu_out <= alu_input1 - alu_input2;
            OP_COMP: alu_out <= (alu_input1 == alu_input2) ? 16'd1 : 16'd0;
            OP_SLI:  alu_out <= alu_input1 << alu_input2[3:0];
            OP_SRI:  alu_out <= alu_input1 >> alu_input2[3:0];
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_req(input int id, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_opcode[5*id +: 5] = op;
      req_in1[W*id +: W]    = a;
      req_in2[W*id +: W]    = b;
   endtask

   // Returns one sample point after the handshake edge (cycle 1, EXEC).
   task automatic issue(input int id, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      int n;
      set_req(id, op, a, b);
      req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[id] && n < 10) begin
         tick();
         #1;
         n++;
      end
      check("issue_grant", 32'(req_ready[id]), 32'd1);
      tick();
      req_valid[id] = 1'b0;
   endtask

   // Called at cycle 1; checks the 3-cycle latency and leaves the bench in IDLE.
   task automatic expect_resp(input string tag, input int id, input logic [W-1:0] data);
      check({tag, "_c1_valid"}, 32'(resp_valid), 32'd0);
      tick();
      check({tag, "_c2_valid"}, 32'(resp_valid), 32'd0);
      tick();
      check({tag, "_c3_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_data"}, 32'(resp_data), 32'(data));
      check({tag, "_id"}, 32'(resp_id), 32'(id));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int g0, r0, r1;
      logic [W-1:0] exp_data [4];

      // Reset state and a single ADD with latency checks.
      do_reset();
      check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      check("rst_alu_input1", 32'(alu_input1), 32'd0);
      check("rst_alu_input2", 32'(alu_input2), 32'd0);
      check("rst_alu_enable", 32'(alu_enable), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(ARB_ST_IDLE));
      check("rst_req_ready", 32'(req_ready), 32'd0);
      set_req(0, OP_ADD, 16'd5, 16'd7);
      req_valid[0] = 1'b1;
      #1;
      check("add_req_ready", 32'(req_ready), 32'b01);
      tick();
      req_valid[0] = 1'b0;
      check("add_alu_enable_c1", 32'(alu_enable), 32'd1);
      check("add_alu_opcode", 32'(alu_opcode), 32'(OP_ADD));
      check("add_alu_input1", 32'(alu_input1), 32'd5);
      check("add_alu_input2", 32'(alu_input2), 32'd7);
      tick();
      check("add_alu_enable_c2", 32'(alu_enable), 32'd0);
      check("add_resp_valid_c2", 32'(resp_valid), 32'd0);
      tick();
      check("add_resp_valid_c3", 32'(resp_valid), 32'd1);
      check("add_resp_data", 32'(resp_data), 32'd12);
      check("add_resp_id", 32'(resp_id), 32'd0);
      tick();

      // Continuous contention: strict alternation 0,1,0,1.
      do_reset();
      set_req(0, OP_ADD, 16'd1, 16'd1);
      set_req(1, OP_SUB, 16'd0, 16'd1);
      exp_data[0] = 16'd2;
      exp_data[1] = 16'hFFFF;
      exp_data[2] = 16'd2;
      exp_data[3] = 16'hFFFF;
      resp_ready = 1'b1;
      req_valid  = 2'b11;
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         tick();
         if (resp_valid) begin
            check("rr_id", 32'(resp_id), 32'(got % 2));
            check("rr_data", 32'(resp_data), 32'(exp_data[got]));
            got++;
         end
      end
      req_valid = '0;
      check("rr_count", 32'(got), 32'd4);

      // Back-pressure: response held stable, no grant until resp_ready.
      do_reset();
      resp_ready = 1'b0;
      issue(0, OP_COMP, 16'd9, 16'd9);
      tick();
      tick();
      set_req(1, OP_ADD, 16'd2, 16'd2);
      req_valid[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_data", 32'(resp_data), 32'd1);
         check("bp_id", 32'(resp_id), 32'd0);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_same_cycle_ready", 32'(req_ready), 32'd0);
      tick();
      #1;
      check("bp_valid_dropped", 32'(resp_valid), 32'd0);
      check("bp_next_grant", 32'(req_ready), 32'b10);
      req_valid = '0;

      // Reset asserted while in EXEC.
      do_reset();
      issue(0, OP_ADD, 16'd2, 16'd2);
      check("mid_enable_before", 32'(alu_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_alu_enable", 32'(alu_enable), 32'd0);
      check("mid_alu_opcode", 32'(alu_opcode), 32'd0);
      check("mid_alu_input1", 32'(alu_input1), 32'd0);
      check("mid_resp_id", 32'(resp_id), 32'd0);
      check("mid_state", 32'(dut.state_q), 32'(ARB_ST_IDLE));
      tick();
      rst_n = 1'b1;
      got = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (resp_valid) got++;
      end
      check("mid_no_resp", 32'(got), 32'd0);
      issue(0, OP_ADD, 16'd3, 16'd4);
      expect_resp("mid_add34", 0, 16'd7);

      // Lone requester 1, shifts, then an opcode the ALU ignores.
      do_reset();
      issue(1, OP_SLI, 16'd1, 16'd4);
      expect_resp("sli", 1, 16'd16);
      issue(1, OP_SRI, 16'd16, 16'd2);
      expect_resp("sri", 1, 16'd4);
      issue(1, OP_LOAD, 16'd3, 16'd3);
      expect_resp("unknown", 1, 16'd4);

      // Requester 0 withdraws while requester 1 holds the grant.
      do_reset();
      issue(0, OP_ADD, 16'd1, 16'd1);
      expect_resp("wd_prime", 0, 16'd2);
      set_req(0, OP_ADD, 16'd8, 16'd8);
      set_req(1, OP_SUB, 16'd9, 16'd3);
      req_valid = 2'b11;
      #1;
      check("wd_grant1", 32'(req_ready), 32'b10);
      tick();
      req_valid = '0;
      g0 = 0;
      r0 = 0;
      r1 = 0;
      for (int c = 0; c < 12; c++) begin
         if (req_ready[0]) g0++;
         if (resp_valid && resp_id == 1'b0) r0++;
         if (resp_valid && resp_id == 1'b1) begin
            r1++;
            check("wd_data", 32'(resp_data), 32'd6);
         end
         tick();
      end
      check("wd_no_grant0", 32'(g0), 32'd0);
      check("wd_no_resp0", 32'(r0), 32'd0);
      check("wd_one_resp1", 32'(r1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
